// File: rtl/boot_readback_tx.sv
// Bootloader readback transmitter: reads a run of program-memory words and
// serializes each as a 32-bit {8'h00, address, data} frame, MSB first.
module boot_readback_tx #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              sclk,
    input  logic              nrst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        count_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [ADDR_W-1:0] raddress_o,
    output logic              pread_o,
    output logic              sdo_o,
    output logic              frame_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        remaining;
    logic [4:0]        bit_cnt;
    logic [31:0]       shreg;
    logic              last_bit;
    logic [31:0]       frame_word;

    assign last_bit   = (bit_cnt == 5'd31);
    assign frame_word = {16'(cur_addr), 16'(rdata_i)};

    // The shift register empties itself after 32 shifts, so its MSB already
    // idles low between frames and can drive the line directly.
    assign sdo_o = shreg[31];

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        next_addr  = cur_addr;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (count_i != 8'd0) begin
                        next_state = READ;
                        next_addr  = addr_i;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            READ:  next_state = CAPT;
            CAPT:  next_state = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    if (remaining == 8'd1) begin
                        next_state = DONE;
                    end else begin
                        next_state = READ;
                        next_addr  = cur_addr + 1'b1;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort_i) begin
            next_state = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            cur_addr   <= '0;
            remaining  <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            raddress_o <= '0;
            pread_o    <= 1'b0;
            frame_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else if (abort_i) begin
            cur_addr   <= '0;
            remaining  <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            raddress_o <= '0;
            pread_o    <= 1'b0;
            frame_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            cur_addr <= next_addr;
            // Outputs are decoded from the next state so they line up with it.
            pread_o  <= (next_state == READ);
            frame_o  <= (next_state == SHIFT);
            busy_o   <= (next_state != IDLE);
            done_o   <= (next_state == DONE);
            if (next_state == READ) begin
                raddress_o <= next_addr;
            end
            case (state)
                IDLE: begin
                    if (start_i && (count_i != 8'd0)) begin
                        remaining <= count_i;
                    end
                end
                CAPT: begin
                    shreg   <= frame_word;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    shreg   <= {shreg[30:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (last_bit) begin
                        remaining <= remaining - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
